// File: rtl/spi_master_engine.sv
// Single-word SPI master shift engine (1..32 bits, MSB first, CPOL/CPHA 0..3) fed by CSR fields.
// Config is latched on start; all outputs are registered.
module spi_master_engine #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_CS = 4,
  parameter int DIV_WIDTH = 16,
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic                          start,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tx_data,
  input  logic [4:0]                    xfer_len,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  input  logic                          cpol,
  input  logic                          cpha,
  input  logic [CS_W-1:0]               cs_sel,
  output logic                          busy,
  output logic                          done,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rx_data,
  output logic                          sclk,
  output logic                          mosi,
  input  logic                          miso,
  output logic [NUM_CS-1:0]             cs_n
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                        state;
  logic [C_S_AXI_DATA_WIDTH-1:0] tx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rx_sr;
  logic [4:0]                    len_q;
  logic [4:0]                    bidx;
  logic [DIV_WIDTH-1:0]          div_q;
  logic [DIV_WIDTH-1:0]          hcnt;
  logic                          cpol_q;
  logic                          cpha_q;
  logic [6:0]                    ecnt;
  logic [6:0]                    edge_num;
  logic [6:0]                    two_n;
  logic                          tick;
  logic                          edge_now;
  logic                          leading;
  logic                          last_edge;
  logic [NUM_CS-1:0]             cs_dec;

  // Out-of-range selects decode to no active chip select.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
    end
  end

  assign tick      = (hcnt == div_q);
  assign two_n     = {1'b0, len_q, 1'b0} + 7'd2;
  assign edge_num  = ecnt + 7'd1;
  assign leading   = edge_num[0];
  assign last_edge = (edge_num == two_n);
  // After the final edge SHIFT keeps running one more half period before HOLD.
  assign edge_now  = tick && ((state == SETUP) || ((state == SHIFT) && (ecnt != two_n)));

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      tx_q    <= '0;
      rx_sr   <= '0;
      len_q   <= '0;
      bidx    <= '0;
      div_q   <= '0;
      hcnt    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      ecnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (start && !done) begin
            tx_q   <= tx_data;
            len_q  <= xfer_len;
            div_q  <= clk_div;
            cpol_q <= cpol;
            cpha_q <= cpha;
            bidx   <= xfer_len;
            hcnt   <= '0;
            ecnt   <= '0;
            rx_sr  <= '0;
            busy   <= 1'b1;
            cs_n   <= cs_dec;
            state  <= SETUP;
            if (!cpha) mosi <= tx_data[xfer_len];
          end
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: if (tick && (ecnt == two_n)) state <= HOLD;
        HOLD:  if (tick) state <= DONE;
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          cs_n    <= '1;
          rx_data <= rx_sr;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if ((state == SETUP) || (state == SHIFT) || (state == HOLD)) begin
        hcnt <= tick ? '0 : hcnt + DIV_WIDTH'(1);
      end

      if (edge_now) begin
        sclk <= ~sclk;
        ecnt <= edge_num;
        if (leading) begin
          if (cpha_q) begin
            mosi <= tx_q[bidx];
            bidx <= bidx - 5'd1;
          end else begin
            rx_sr <= {rx_sr[C_S_AXI_DATA_WIDTH-2:0], miso};
          end
        end else begin
          if (cpha_q) begin
            rx_sr <= {rx_sr[C_S_AXI_DATA_WIDTH-2:0], miso};
          end else if (!last_edge) begin
            mosi <= tx_q[bidx - 5'd1];
            bidx <= bidx - 5'd1;
          end
        end
      end
    end
  end

endmodule
